bram_port_arbiter: RTL

Arbiter and boot sequencer for port B of the shared instruction/data BRAM (`inferredBRAM`). It shares the port between two requesters:
- the CPU load/store unit;
- the program loader, which writes the program image at boot.

After reset it holds the CPU off the memory until the loader signals completion, then round-robin arbitrates both requesters. Read data is routed back to whichever requester issued the access.

---
 rtl/bram_arb_pkg.sv | 18 +
 rtl/bram_port_arbiter_rr_arb2.sv | 47 ++++
 rtl/bram_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port B arbiter: boot FSM states, response
// owner tags and the stall counter width.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } arbState_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_LDR = 1'b1
  } owner_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-way round-robin picker. On a tie the requester that did not win
// the previous grant wins; the loader counts as the last winner after
// reset, so the CPU takes the first tie.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic reqCpu,
  input  logic reqLdr,
  output logic gntCpu,
  output logic gntLdr
);

  owner_t lastWinner;

  // Pick a winner from the live requests and the last winner.
  always_comb begin
    gntCpu = 1'b0;
    gntLdr = 1'b0;
    if (enable) begin
      if (reqCpu && reqLdr) begin
        if (lastWinner == OWNER_LDR) begin
          gntCpu = 1'b1;
        end else begin
          gntLdr = 1'b1;
        end
      end else begin
        gntCpu = reqCpu;
        gntLdr = reqLdr;
      end
    end
  end

  // Remember who was granted most recently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastWinner <= OWNER_LDR;
    end else if (gntCpu) begin
      lastWinner <= OWNER_CPU;
    end else if (gntLdr) begin
      lastWinner <= OWNER_LDR;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Port B arbiter and boot sequencer for the shared instruction/data BRAM.
// The loader owns the port during boot; after a one-cycle flush the CPU
// and loader share it round-robin. Responses are tagged with their owner
// so the registered read data returns to the requester that issued it.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic [NUM_COL-1:0]     cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [DATA_WIDTH-1:0]  cpu_rdata,
  input  logic                   ldr_req,
  input  logic [NUM_COL-1:0]     ldr_we,
  input  logic [ADDR_WIDTH-1:0]  ldr_addr,
  input  logic [DATA_WIDTH-1:0]  ldr_wdata,
  output logic                   ldr_gnt,
  output logic                   ldr_rvalid,
  output logic [DATA_WIDTH-1:0]  ldr_rdata,
  input  logic                   ldr_boot_done,
  output logic                   cpu_hold,
  output logic                   bram_en,
  output logic [NUM_COL-1:0]     bram_we,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  output logic [DATA_WIDTH-1:0]  bram_din,
  input  logic [DATA_WIDTH-1:0]  bram_dout,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  arbState_t state;
  arbState_t nextState;
  logic      arbCpuGnt;
  logic      arbLdrGnt;
  logic      respValid;
  owner_t    respOwner;

  rr_arb2 uArb (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ST_RUN),
    .reqCpu (cpu_req),
    .reqLdr (ldr_req),
    .gntCpu (arbCpuGnt),
    .gntLdr (arbLdrGnt)
  );

  // Boot sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_BOOT;
    end else begin
      state <= nextState;
    end
  end

  // Next state, grants and CPU hold; grants are forced low while reset is asserted.
  always_comb begin
    nextState = state;
    cpu_gnt   = 1'b0;
    ldr_gnt   = 1'b0;
    cpu_hold  = (state != ST_RUN);
    case (state)
      ST_BOOT: begin
        ldr_gnt = ldr_req & reset;
        if (ldr_boot_done) begin
          nextState = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        nextState = ST_RUN;
      end
      ST_RUN: begin
        cpu_gnt = arbCpuGnt & reset;
        ldr_gnt = arbLdrGnt & reset;
      end
      default: begin
        nextState = ST_BOOT;
      end
    endcase
  end

  // Steer the granted requester onto BRAM port B, all zeros when idle.
  always_comb begin
    bram_en   = cpu_gnt | ldr_gnt;
    bram_we   = '0;
    bram_addr = '0;
    bram_din  = '0;
    if (cpu_gnt) begin
      bram_we   = cpu_we;
      bram_addr = cpu_addr;
      bram_din  = cpu_wdata;
    end else if (ldr_gnt) begin
      bram_we   = ldr_we;
      bram_addr = ldr_addr;
      bram_din  = ldr_wdata;
    end
  end

  // Tag each granted access so its response returns to the right requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      respValid <= 1'b0;
      respOwner <= OWNER_CPU;
    end else begin
      respValid <= cpu_gnt | ldr_gnt;
      respOwner <= ldr_gnt ? OWNER_LDR : OWNER_CPU;
    end
  end

  assign cpu_rvalid = respValid & (respOwner == OWNER_CPU);
  assign ldr_rvalid = respValid & (respOwner == OWNER_LDR);
  assign cpu_rdata  = bram_dout;
  assign ldr_rdata  = bram_dout;

  // Count RUN cycles in which the CPU asked for the port and was refused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if ((state == ST_RUN) && cpu_req && !cpu_gnt && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule
